// File: rtl/dotacc_tile_seq.sv
// dotacc_tile_seq: tile sequencer for the DOTACC address generator.
// Takes one layer command, then issues one AGU start per tile with per-tile
// start addresses and first/last-tiling flags, waiting for AGU completion
// (guarded by a watchdog) and an optional idle gap before re-arming.
module dotacc_tile_seq #(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned TO_W       = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [15:0] i_base_addr,
  input  logic [15:0] i_base_addr2,
  input  logic [15:0] i_tile_stride,
  input  logic [7:0]  i_tile_num,
  input  logic [7:0]  i_in_piece,
  input  logic [7:0]  i_out_piece,
  input  logic        i_square_mode,
  input  logic        i_src_from2buffer,
  input  logic        i_pe_ready,
  input  logic        i_agu_done,
  input  logic        i_abort,
  output logic        o_AGUStart,
  output logic [15:0] o_StartAdder,
  output logic [15:0] o_StartAdder2,
  output logic [7:0]  o_Input_PieceNum,
  output logic [7:0]  o_Out_PieceNum,
  output logic        o_square_mode,
  output logic        o_src_from2buffer,
  output logic        o_bFirstTiling,
  output logic        o_bLastTiling,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int unsigned     GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [TO_W-1:0]  WD_LAST  = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;
  localparam bit               WD_ON    = (TIMEOUT > 0);
  localparam bit               HAS_GAP  = (GAP_CYCLES > 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_GAP,
    S_DONE
  } state_t;

  state_t state, stateNext;

  logic [7:0]       tileIdx;
  logic [7:0]       tileNum;
  logic [15:0]      stride;
  logic [TO_W-1:0]  wdog;
  logic [GAP_W-1:0] gapCnt;
  logic             startQ;
  logic             errQ;

  logic zeroCmd;
  logic isLast;
  logic loadCmd;
  logic startNext;
  logic errNext;
  logic advance;
  logic clearIdx;
  logic wdogClr;
  logic wdogInc;
  logic gapClr;
  logic gapInc;

  assign zeroCmd = (i_tile_num == '0) | (i_in_piece == '0) | (i_out_piece == '0);
  assign isLast  = (tileIdx == (tileNum - 8'd1));

  // Next-state and control strobes; abort overrides everything at the end.
  always_comb begin
    stateNext = state;
    loadCmd   = 1'b0;
    startNext = 1'b0;
    errNext   = 1'b0;
    advance   = 1'b0;
    clearIdx  = 1'b0;
    wdogClr   = 1'b0;
    wdogInc   = 1'b0;
    gapClr    = 1'b0;
    gapInc    = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          loadCmd = 1'b1;
          if (zeroCmd) begin
            errNext = 1'b1;
          end else begin
            stateNext = S_ARM;
          end
        end
      end
      S_ARM: begin
        if (i_pe_ready) begin
          startNext = 1'b1;
          wdogClr   = 1'b1;
          stateNext = S_RUN;
        end
      end
      S_RUN: begin
        if (i_agu_done) begin
          if (isLast) begin
            stateNext = S_DONE;
          end else begin
            advance   = 1'b1;
            gapClr    = 1'b1;
            stateNext = HAS_GAP ? S_GAP : S_ARM;
          end
        end else if (WD_ON && (wdog == WD_LAST)) begin
          errNext   = 1'b1;
          stateNext = S_IDLE;
        end else if (WD_ON) begin
          wdogInc = 1'b1;
        end
      end
      S_GAP: begin
        if (gapCnt == GAP_LAST) begin
          stateNext = S_ARM;
        end else begin
          gapInc = 1'b1;
        end
      end
      S_DONE: begin
        stateNext = S_IDLE;
      end
      default: begin
        stateNext = S_IDLE;
      end
    endcase
    if (i_abort) begin
      stateNext = S_IDLE;
      loadCmd   = 1'b0;
      startNext = 1'b0;
      errNext   = 1'b0;
      advance   = 1'b0;
      clearIdx  = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Registered single-cycle start and error pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      startQ <= 1'b0;
      errQ   <= 1'b0;
    end else begin
      startQ <= startNext;
      errQ   <= errNext;
    end
  end

  // Per-tile watchdog, cleared when the AGU is started.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wdog <= '0;
    end else if (wdogClr) begin
      wdog <= '0;
    end else if (wdogInc) begin
      wdog <= wdog + 1'b1;
    end
  end

  // Idle-gap counter between AGU completion and re-arm.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gapCnt <= '0;
    end else if (gapClr) begin
      gapCnt <= '0;
    end else if (gapInc) begin
      gapCnt <= gapCnt + 1'b1;
    end
  end

  // Command latch and tile index / address stepping (16-bit wraparound).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tileIdx           <= '0;
      tileNum           <= '0;
      stride            <= '0;
      o_StartAdder      <= '0;
      o_StartAdder2     <= '0;
      o_Input_PieceNum  <= '0;
      o_Out_PieceNum    <= '0;
      o_square_mode     <= 1'b0;
      o_src_from2buffer <= 1'b0;
    end else if (loadCmd) begin
      tileIdx           <= '0;
      tileNum           <= i_tile_num;
      stride            <= i_tile_stride;
      o_StartAdder      <= i_base_addr;
      o_StartAdder2     <= i_base_addr2;
      o_Input_PieceNum  <= i_in_piece;
      o_Out_PieceNum    <= i_out_piece;
      o_square_mode     <= i_square_mode;
      o_src_from2buffer <= i_src_from2buffer;
    end else if (clearIdx) begin
      tileIdx <= '0;
    end else if (advance) begin
      tileIdx       <= tileIdx + 8'd1;
      o_StartAdder  <= o_StartAdder + stride;
      o_StartAdder2 <= o_StartAdder2 + stride;
    end
  end

  // Abort masks a start pulse already on the wire in the same cycle.
  assign o_AGUStart     = startQ & ~i_abort;
  assign o_err          = errQ;
  assign o_done         = (state == S_DONE);
  assign o_cmd_ready    = (state == S_IDLE);
  assign o_busy         = (state != S_IDLE);
  assign o_bFirstTiling = (state != S_IDLE) && (tileIdx == '0);
  assign o_bLastTiling  = (state != S_IDLE) && isLast;

endmodule

// File: tb/tb_dotacc_tile_seq.sv
// tb_dotacc_tile_seq: directed plus randomized checks of the tile sequencer
// against expected tile addresses computed as base + k*stride.
module tb_dotacc_tile_seq;

  localparam int GAP = 2;
  localparam int TMO = 64;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [15:0] i_base_addr;
  logic [15:0] i_base_addr2;
  logic [15:0] i_tile_stride;
  logic [7:0]  i_tile_num;
  logic [7:0]  i_in_piece;
  logic [7:0]  i_out_piece;
  logic        i_square_mode;
  logic        i_src_from2buffer;
  logic        i_pe_ready;
  logic        i_agu_done;
  logic        i_abort;
  logic        o_AGUStart;
  logic [15:0] o_StartAdder;
  logic [15:0] o_StartAdder2;
  logic [7:0]  o_Input_PieceNum;
  logic [7:0]  o_Out_PieceNum;
  logic        o_square_mode;
  logic        o_src_from2buffer;
  logic        o_bFirstTiling;
  logic        o_bLastTiling;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  dotacc_tile_seq #(
    .GAP_CYCLES(GAP),
    .TIMEOUT   (TMO),
    .TO_W      (16)
  ) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_cmd_valid      (i_cmd_valid),
    .o_cmd_ready      (o_cmd_ready),
    .i_base_addr      (i_base_addr),
    .i_base_addr2     (i_base_addr2),
    .i_tile_stride    (i_tile_stride),
    .i_tile_num       (i_tile_num),
    .i_in_piece       (i_in_piece),
    .i_out_piece      (i_out_piece),
    .i_square_mode    (i_square_mode),
    .i_src_from2buffer(i_src_from2buffer),
    .i_pe_ready       (i_pe_ready),
    .i_agu_done       (i_agu_done),
    .i_abort          (i_abort),
    .o_AGUStart       (o_AGUStart),
    .o_StartAdder     (o_StartAdder),
    .o_StartAdder2    (o_StartAdder2),
    .o_Input_PieceNum (o_Input_PieceNum),
    .o_Out_PieceNum   (o_Out_PieceNum),
    .o_square_mode    (o_square_mode),
    .o_src_from2buffer(o_src_from2buffer),
    .o_bFirstTiling   (o_bFirstTiling),
    .o_bLastTiling    (o_bLastTiling),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_err            (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;
  int startSeen = 0;
  int doneSeen  = 0;
  int errSeen   = 0;

  // Current command as the reference model sees it.
  logic [15:0] cBase, cBase2, cStride;
  logic [7:0]  cN, cIn, cOut;
  logic        cSq, cSrc;

  // Pulse counters, sampled at the active edge (value of the cycle just ended).
  always @(posedge i_clk) begin
    if (o_AGUStart === 1'b1) startSeen++;
    if (o_done === 1'b1) doneSeen++;
    if (o_err === 1'b1) errSeen++;
  end

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkTile(input int k);
    logic [15:0] ea, ea2;
    ea  = 16'(32'(cBase) + 32'(k) * 32'(cStride));
    ea2 = 16'(32'(cBase2) + 32'(k) * 32'(cStride));
    check("tile_addr", o_StartAdder, ea);
    check("tile_addr2", o_StartAdder2, ea2);
    check("tile_first", o_bFirstTiling, (k == 0));
    check("tile_last", o_bLastTiling, (k == int'(cN) - 1));
    check("in_piece", o_Input_PieceNum, cIn);
    check("out_piece", o_Out_PieceNum, cOut);
    check("square", o_square_mode, cSq);
    check("src2", o_src_from2buffer, cSrc);
  endtask

  task automatic doCmd(input logic [15:0] b, input logic [15:0] b2, input logic [15:0] s,
                       input logic [7:0] n, input logic [7:0] ip, input logic [7:0] op,
                       input logic sq, input logic src);
    cBase = b; cBase2 = b2; cStride = s; cN = n; cIn = ip; cOut = op; cSq = sq; cSrc = src;
    check("cmd_ready_before", o_cmd_ready, 1);
    i_base_addr = b; i_base_addr2 = b2; i_tile_stride = s; i_tile_num = n;
    i_in_piece = ip; i_out_piece = op; i_square_mode = sq; i_src_from2buffer = src;
    i_cmd_valid = 1'b1;
    tick();
    i_cmd_valid = 1'b0;
    i_base_addr = 16'($urandom); i_base_addr2 = 16'($urandom); i_tile_stride = 16'($urandom);
    i_tile_num = 8'($urandom); i_in_piece = 8'($urandom); i_out_piece = 8'($urandom);
    i_square_mode = 1'($urandom); i_src_from2buffer = 1'($urandom);
  endtask

  // Drives all tiles of the current command from the first ARM cycle.
  task automatic runTiles(input int abortTile, input int waitLo, input int waitHi,
                          input int runLo, input int runHi);
    int w, d;
    for (int k = 0; k < int'(cN); k++) begin
      if (k > 0) begin
        for (int g = 0; g < GAP; g++) begin
          i_pe_ready = 1'($urandom);
          i_agu_done = 1'($urandom);
          tick();
          check("gap_nostart", o_AGUStart, 0);
        end
      end
      w = $urandom_range(waitHi, waitLo);
      for (int i = 0; i < w; i++) begin
        i_pe_ready = 1'b0;
        i_agu_done = 1'($urandom);
        tick();
        check("arm_nostart", o_AGUStart, 0);
        check("arm_busy", o_busy, 1);
      end
      i_pe_ready = 1'b1;
      i_agu_done = 1'($urandom);
      tick();
      i_agu_done = 1'b0;
      check("start", o_AGUStart, 1);
      checkTile(k);
      if (k == abortTile) begin
        i_abort = 1'b1;
        #1;
        check("abort_mask_start", o_AGUStart, 0);
        tick();
        i_abort = 1'b0;
        check("abort_idle_ready", o_cmd_ready, 1);
        check("abort_busy", o_busy, 0);
        check("abort_no_done", o_done, 0);
        check("abort_no_err", o_err, 0);
        check("abort_first", o_bFirstTiling, 0);
        return;
      end
      i_pe_ready = 1'($urandom);
      d = $urandom_range(runHi, runLo);
      for (int i = 0; i < d; i++) begin
        tick();
        check("run_nostart", o_AGUStart, 0);
        check("run_nodone", o_done, 0);
      end
      i_agu_done = 1'b1;
      tick();
      i_agu_done = 1'b0;
      check("start_one_cycle", o_AGUStart, 0);
      if (k == int'(cN) - 1) begin
        check("done_pulse", o_done, 1);
        check("done_busy", o_busy, 1);
        tick();
        check("done_cleared", o_done, 0);
        check("idle_ready", o_cmd_ready, 1);
        check("idle_busy", o_busy, 0);
        check("idle_first", o_bFirstTiling, 0);
        check("idle_last", o_bLastTiling, 0);
      end else begin
        check("no_early_done", o_done, 0);
        checkTile(k + 1);
      end
    end
  endtask

  task automatic fullCmd(input logic [15:0] b, input logic [15:0] b2, input logic [15:0] s,
                         input logic [7:0] n, input int waitLo, input int waitHi,
                         input int runLo, input int runHi);
    int s0, d0, e0;
    s0 = startSeen; d0 = doneSeen; e0 = errSeen;
    doCmd(b, b2, s, n, 8'($urandom_range(255, 1)), 8'($urandom_range(255, 1)),
          1'($urandom), 1'($urandom));
    check("arm_busy_entry", o_busy, 1);
    check("arm_not_ready", o_cmd_ready, 0);
    check("arm_no_start", o_AGUStart, 0);
    checkTile(0);
    runTiles(-1, waitLo, waitHi, runLo, runHi);
    check("start_count", startSeen - s0, int'(n));
    check("done_count", doneSeen - d0, 1);
    check("err_count", errSeen - e0, 0);
  endtask

  initial begin
    int s0, d0, e0, which;
    logic [7:0] zn, zi, zo;
    i_rst_n = 1'b0; i_cmd_valid = 1'b0; i_base_addr = '0; i_base_addr2 = '0;
    i_tile_stride = '0; i_tile_num = '0; i_in_piece = '0; i_out_piece = '0;
    i_square_mode = 1'b0; i_src_from2buffer = 1'b0; i_pe_ready = 1'b0;
    i_agu_done = 1'b0; i_abort = 1'b0;
    repeat (3) tick();
    check("rst_ready", o_cmd_ready, 1);
    check("rst_busy", o_busy, 0);
    check("rst_start", o_AGUStart, 0);
    check("rst_addr", o_StartAdder, 0);
    check("rst_addr2", o_StartAdder2, 0);
    check("rst_flags", {o_bFirstTiling, o_bLastTiling}, 0);
    check("rst_done_err", {o_done, o_err}, 0);
    i_rst_n = 1'b1;
    tick();
    check("post_rst_ready", o_cmd_ready, 1);

    // Single tile, done 10 cycles after start.
    fullCmd(16'h0100, 16'($urandom), 16'($urandom), 8'd1, 0, 0, 9, 9);
    // Three tiles with known addresses.
    fullCmd(16'h0010, 16'h1010, 16'h0020, 8'd3, 0, 3, 0, 6);
    // Backpressure: ready held low 20 cycles in ARM.
    fullCmd(16'($urandom), 16'($urandom), 16'($urandom), 8'd2, 20, 20, 2, 5);

    // Zero-count command.
    s0 = startSeen; e0 = errSeen;
    which = $urandom_range(2, 0);
    zn = (which == 0) ? 8'd0 : 8'd3;
    zi = (which == 1) ? 8'd0 : 8'd5;
    zo = (which == 2) ? 8'd0 : 8'd7;
    doCmd(16'($urandom), 16'($urandom), 16'($urandom), zn, zi, zo, 1'b0, 1'b0);
    check("zero_err", o_err, 1);
    check("zero_ready", o_cmd_ready, 1);
    check("zero_busy", o_busy, 0);
    tick();
    check("zero_err_pulse", o_err, 0);
    check("zero_ready2", o_cmd_ready, 1);
    check("zero_no_start", startSeen - s0, 0);
    check("zero_err_count", errSeen - e0, 1);

    // Watchdog timeout.
    d0 = doneSeen; e0 = errSeen;
    doCmd(16'($urandom), 16'($urandom), 16'($urandom), 8'd1, 8'd4, 8'd4, 1'b1, 1'b0);
    i_pe_ready = 1'b1;
    tick();
    check("to_start", o_AGUStart, 1);
    for (int i = 1; i < TMO; i++) begin
      tick();
      check("to_no_err_early", o_err, 0);
      check("to_busy", o_busy, 1);
    end
    tick();
    check("to_err", o_err, 1);
    check("to_idle", o_busy, 0);
    check("to_ready", o_cmd_ready, 1);
    check("to_no_done", o_done, 0);
    tick();
    check("to_err_pulse", o_err, 0);
    check("to_done_count", doneSeen - d0, 0);
    check("to_err_count", errSeen - e0, 1);

    // Abort during tile 1 of 4, then a fresh command.
    s0 = startSeen; d0 = doneSeen; e0 = errSeen;
    doCmd(16'($urandom), 16'($urandom), 16'($urandom), 8'd4, 8'd2, 8'd9, 1'b0, 1'b1);
    runTiles(1, 0, 2, 0, 4);
    check("abort_start_count", startSeen - s0, 1);
    check("abort_done_count", doneSeen - d0, 0);
    check("abort_err_count", errSeen - e0, 0);
    fullCmd(16'($urandom), 16'($urandom), 16'($urandom), 8'd2, 0, 2, 0, 3);

    // Abort in ARM while ready is high: no start follows.
    s0 = startSeen;
    doCmd(16'($urandom), 16'($urandom), 16'($urandom), 8'd2, 8'd1, 8'd1, 1'b0, 1'b0);
    i_pe_ready = 1'b1;
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("arm_abort_idle", o_cmd_ready, 1);
    check("arm_abort_start", o_AGUStart, 0);
    tick();
    check("arm_abort_start2", o_AGUStart, 0);
    check("arm_abort_count", startSeen - s0, 0);

    // Reset asserted mid-RUN.
    doCmd(16'hABCD, 16'h1234, 16'h0011, 8'd2, 8'd6, 8'd6, 1'b1, 1'b1);
    i_pe_ready = 1'b1;
    tick();
    check("rr_start", o_AGUStart, 1);
    tick();
    i_rst_n = 1'b0;
    #1;
    check("rr_ready", o_cmd_ready, 1);
    check("rr_busy", o_busy, 0);
    check("rr_addr", o_StartAdder, 0);
    check("rr_addr2", o_StartAdder2, 0);
    check("rr_pieces", {o_Input_PieceNum, o_Out_PieceNum}, 0);
    check("rr_modes", {o_square_mode, o_src_from2buffer}, 0);
    check("rr_flags", {o_bFirstTiling, o_bLastTiling, o_AGUStart, o_done, o_err}, 0);
    tick();
    i_rst_n = 1'b1;
    tick();
    check("rr_ready_after", o_cmd_ready, 1);

    // Address wrap.
    fullCmd(16'hFFF0, 16'($urandom), 16'h0010, 8'd2, 0, 1, 0, 3);

    // Random commands.
    for (int r = 0; r < 8; r++) begin
      fullCmd(16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom_range(6, 1)),
              0, 4, 0, 8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
